// File: rtl/digdug_rom_loader.sv
// Dig Dug ROM download sequencer: region decode, byte count,
// additive checksum and core reset ownership.
module digdug_rom_loader #(
  parameter int                    NUM_REG  = 8,
  parameter logic [NUM_REG*17-1:0] REG_END  = {17'h0A000, 17'h09000,
                                               17'h08000, 17'h07800,
                                               17'h07000, 17'h06000,
                                               17'h04000, 17'h00000},
  parameter logic [16:0]           EXPECT   = 17'h0A000,
  parameter int                    HOLD_CYC = 1024
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               user_rst,
  output logic [NUM_REG-1:0] rom_we,
  output logic [15:0]        rom_ad,
  output logic [7:0]         rom_dt,
  output logic               core_reset,
  output logic               load_done,
  output logic               err_ovf,
  output logic               err_short,
  output logic [15:0]        checksum
);

  localparam int HW = $clog2(HOLD_CYC) + 1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_armed;
  logic [HW-1:0]      r_hold;
  logic [16:0]        r_cnt;
  logic [15:0]        r_sum;
  logic               r_ovf;
  logic               r_short;
  logic               r_done;
  logic [NUM_REG-1:0] r_we;
  logic [15:0]        r_ad;
  logic [7:0]         r_dt;

  logic               w_wr_ok;
  logic               w_in;
  logic               w_found;
  logic [NUM_REG-1:0] w_we;
  logic [15:0]        w_off;
  logic               w_start;
  logic               w_hold_ld;
  logic               w_done;
  logic               w_short;

  assign w_wr_ok = (r_state == S_LOAD) && ioctl_download && ioctl_wr;
  assign w_in    = ioctl_addr < {8'd0, EXPECT};
  // A download starts only after the window was seen low since reset.
  assign w_start = ioctl_download && r_armed && (r_state != S_LOAD);

  // Region decode: first region whose end lies above the address.
  always_comb begin
    logic [16:0] v_lo;
    logic [16:0] v_hi;
    w_found = 1'b0;
    w_we    = '0;
    w_off   = '0;
    v_lo    = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      v_hi = REG_END[i*17 +: 17];
      if (!w_found && (ioctl_addr < {8'd0, v_hi})) begin
        w_found = 1'b1;
        w_we[i] = 1'b1;
        w_off   = ioctl_addr[15:0] - v_lo[15:0];
      end
      v_lo = v_hi;
    end
  end

  // Next-state logic and one-cycle event flags.
  always_comb begin
    w_next    = r_state;
    w_hold_ld = 1'b0;
    w_done    = 1'b0;
    w_short   = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (w_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (!ioctl_download) begin
          if (r_cnt == EXPECT) begin
            w_next    = S_HOLD;
            w_hold_ld = 1'b1;
            w_done    = 1'b1;
          end else begin
            w_next  = S_WAIT;
            w_short = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_start) begin
          w_next = S_LOAD;
        end else if (user_rst) begin
          w_hold_ld = 1'b1;
        end else if (r_hold == HW'(HOLD_CYC - 1)) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_start) begin
          w_next = S_LOAD;
        end else if (user_rst) begin
          w_next    = S_HOLD;
          w_hold_ld = 1'b1;
        end
      end
      default: w_next = S_WAIT;
    endcase
  end

  // State register and download-window arming.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_WAIT;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!ioctl_download) r_armed <= 1'b1;
    end
  end

  // Reset hold counter.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_hold <= '0;
    end else if (w_hold_ld) begin
      r_hold <= '0;
    end else if (r_state == S_HOLD) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Registered write port toward the ROM regions.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_we <= '0;
      r_ad <= '0;
      r_dt <= '0;
    end else begin
      r_we <= '0;
      if (w_wr_ok && w_in && w_found) begin
        r_we <= w_we;
        r_ad <= w_off;
        r_dt <= ioctl_dout;
      end
    end
  end

  // Byte count, checksum and status flags of the current download.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_short <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_short <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        if (w_in) begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          r_sum <= r_sum + {8'd0, ioctl_dout};
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (w_done)  r_done  <= 1'b1;
      if (w_short) r_short <= 1'b1;
    end
  end

  assign rom_we     = r_we;
  assign rom_ad     = r_ad;
  assign rom_dt     = r_dt;
  assign core_reset = (r_state != S_RUN);
  assign load_done  = r_done;
  assign err_ovf    = r_ovf;
  assign err_short  = r_short;
  assign checksum   = r_sum;

endmodule

// File: tb/tb_digdug_rom_loader.sv
// Directed bench for digdug_rom_loader: loads, boundaries,
// overflow, short load, user reset and async reset mid-load.
module tb_digdug_rom_loader;

  localparam int HOLD = 1024;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_rst;
  logic [7:0]  rom_we;
  logic [15:0] rom_ad;
  logic [7:0]  rom_dt;
  logic        core_reset;
  logic        load_done;
  logic        err_ovf;
  logic        err_short;
  logic [15:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  int n_strobe;
  int n_multi;
  int reg_cnt[8];

  digdug_rom_loader #(.HOLD_CYC(HOLD)) dut (
    .MCLK           (MCLK),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_rst       (user_rst),
    .rom_we         (rom_we),
    .rom_ad         (rom_ad),
    .rom_dt         (rom_dt),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .err_ovf        (err_ovf),
    .err_short      (err_short),
    .checksum       (checksum)
  );

  always #5 MCLK = ~MCLK;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge MCLK) begin
    if (rom_we != 8'h00) begin
      n_strobe = n_strobe + 1;
      if ($countones(rom_we) != 1) n_multi = n_multi + 1;
      for (int i = 0; i < 8; i++)
        if (rom_we[i]) reg_cnt[i] = reg_cnt[i] + 1;
    end
  end

  task automatic clr_mon();
    n_strobe = 0;
    n_multi  = 0;
    for (int i = 0; i < 8; i++) reg_cnt[i] = 0;
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge MCLK);
    #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge MCLK);
    #1;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    user_rst = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    RESET = 1'b0;
    @(posedge MCLK);
    #1;
    n_cmp++;
    if ({rom_we, rom_ad, rom_dt, checksum} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data we=%h ad=%h dt=%h sum=%h want 0",
               rom_we, rom_ad, rom_dt, checksum);
    end
    n_cmp++;
    if ({core_reset, load_done, err_ovf, err_short} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 1000",
               {core_reset, load_done, err_ovf, err_short});
    end
  endtask

  task automatic test_wr_ignored();
    clr_mon();
    write_byte(25'h00010, 8'h5A);
    @(posedge MCLK);
    #1;
    n_cmp++;
    if (n_strobe !== 0 || checksum !== 16'h0) begin
      n_bad++;
      $display("FAIL wr_no_window strobes=%0d sum=%h want 0/0",
               n_strobe, checksum);
    end
  endtask

  task automatic test_boundary();
    start_dl();
    write_byte(25'h03FFF, 8'h11);
    n_cmp++;
    if (rom_we !== 8'h02 || rom_ad !== 16'h3FFF || rom_dt !== 8'h11) begin
      n_bad++;
      $display("FAIL bnd_3fff we=%h ad=%h dt=%h want 02/3fff/11",
               rom_we, rom_ad, rom_dt);
    end
    write_byte(25'h04000, 8'h22);
    n_cmp++;
    if (rom_we !== 8'h04 || rom_ad !== 16'h0000 || rom_dt !== 8'h22) begin
      n_bad++;
      $display("FAIL bnd_4000 we=%h ad=%h dt=%h want 04/0000/22",
               rom_we, rom_ad, rom_dt);
    end
    @(posedge MCLK);
    #1;
    n_cmp++;
    if (rom_we !== 8'h00 || checksum !== 16'h0033) begin
      n_bad++;
      $display("FAIL bnd_after we=%h sum=%h want 00/0033", rom_we, checksum);
    end
    end_dl();
    n_cmp++;
    if (err_short !== 1'b1 || load_done !== 1'b0) begin
      n_bad++;
      $display("FAIL bnd_short short=%b done=%b want 1/0",
               err_short, load_done);
    end
  endtask

  task automatic test_short_load();
    start_dl();
    n_cmp++;
    if (err_short !== 1'b0 || checksum !== 16'h0) begin
      n_bad++;
      $display("FAIL short_entry short=%b sum=%h want 0/0",
               err_short, checksum);
    end
    for (int a = 'h9FF0; a <= 'h9FFE; a++)
      write_byte(25'(a), 8'(a));
    n_cmp++;
    if (rom_we !== 8'h80 || rom_ad !== 16'h0FFE || rom_dt !== 8'hFE) begin
      n_bad++;
      $display("FAIL short_last we=%h ad=%h dt=%h want 80/0ffe/fe",
               rom_we, rom_ad, rom_dt);
    end
    end_dl();
    repeat (HOLD + 500) @(posedge MCLK);
    #1;
    n_cmp++;
    if (err_short !== 1'b1 || load_done !== 1'b0 || core_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL short_end short=%b done=%b crst=%b want 1/0/1",
               err_short, load_done, core_reset);
    end
    n_cmp++;
    if (checksum !== 16'h0E79) begin
      n_bad++;
      $display("FAIL short_sum got %h want 0e79", checksum);
    end
    user_rst = 1'b1;
    repeat (3) @(posedge MCLK);
    #1;
    user_rst = 1'b0;
    n_cmp++;
    if (core_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_user_rst crst=%b want 1", core_reset);
    end
  endtask

  task automatic test_full_load();
    int n;
    clr_mon();
    start_dl();
    for (int a = 0; a < 'hA000; a++) begin
      if (a == 'h5000) begin
        write_byte(25'h0A000, 8'h55);
        n_cmp++;
        if (rom_we !== 8'h00 || err_ovf !== 1'b1) begin
          n_bad++;
          $display("FAIL ovf_write we=%h ovf=%b want 00/1", rom_we, err_ovf);
        end
      end
      write_byte(25'(a), 8'(a));
    end
    ioctl_download = 1'b0;
    n = 0;
    do begin
      @(posedge MCLK);
      #1;
      n++;
      if (n == 1) begin
        n_cmp++;
        if (load_done !== 1'b1 || err_short !== 1'b0 || core_reset !== 1'b1) begin
          n_bad++;
          $display("FAIL full_done done=%b short=%b crst=%b want 1/0/1",
                   load_done, err_short, core_reset);
        end
      end
    end while (core_reset && n < 5000);
    n_cmp++;
    if (n !== HOLD + 1) begin
      n_bad++;
      $display("FAIL full_rst_len got %0d want %0d", n, HOLD + 1);
    end
    // 160 runs of 0x00..0xFF, each summing to 0x7F80.
    n_cmp++;
    if (checksum !== 16'hB000 || err_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL full_sum sum=%h ovf=%b want b000/1", checksum, err_ovf);
    end
    n_cmp++;
    if (n_strobe !== 40960 || n_multi !== 0) begin
      n_bad++;
      $display("FAIL full_strobes got %0d multi=%0d want 40960/0",
               n_strobe, n_multi);
    end
    n_cmp++;
    if (reg_cnt[0] !== 0 || reg_cnt[1] !== 'h4000 ||
        reg_cnt[2] !== 'h2000 || reg_cnt[3] !== 'h1000 ||
        reg_cnt[4] !== 'h800 || reg_cnt[5] !== 'h800 ||
        reg_cnt[6] !== 'h1000 || reg_cnt[7] !== 'h1000) begin
      n_bad++;
      $display("FAIL full_regions %0d %0d %0d %0d %0d %0d %0d %0d want 0 16384 8192 4096 2048 2048 4096 4096",
               reg_cnt[0], reg_cnt[1], reg_cnt[2], reg_cnt[3],
               reg_cnt[4], reg_cnt[5], reg_cnt[6], reg_cnt[7]);
    end
  endtask

  task automatic test_user_rst();
    int n;
    n_cmp++;
    if (core_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL run_state crst=%b want 0", core_reset);
    end
    user_rst = 1'b1;
    n = 0;
    repeat (3) begin
      @(posedge MCLK);
      #1;
      n++;
    end
    user_rst = 1'b0;
    n_cmp++;
    if (core_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL urst_assert crst=%b want 1", core_reset);
    end
    while (core_reset && n < 5000) begin
      @(posedge MCLK);
      #1;
      n++;
    end
    n_cmp++;
    if (n !== HOLD + 3) begin
      n_bad++;
      $display("FAIL urst_len got %0d want %0d", n, HOLD + 3);
    end
    n_cmp++;
    if (load_done !== 1'b1) begin
      n_bad++;
      $display("FAIL urst_done got %b want 1", load_done);
    end
  endtask

  task automatic test_reset_mid_load();
    start_dl();
    n_cmp++;
    if (load_done !== 1'b0 || err_ovf !== 1'b0 || core_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_entry done=%b ovf=%b crst=%b want 0/0/1",
               load_done, err_ovf, core_reset);
    end
    for (int a = 0; a <= 'h1000; a++)
      write_byte(25'(a), 8'(a));
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({rom_we, rom_ad, rom_dt, checksum} !== 48'h0 ||
        {core_reset, load_done, err_ovf, err_short} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_reset we=%h ad=%h dt=%h sum=%h flags=%b want zeros/1000",
               rom_we, rom_ad, rom_dt, checksum,
               {core_reset, load_done, err_ovf, err_short});
    end
    repeat (2) @(posedge MCLK);
    #1;
    RESET = 1'b0;
    clr_mon();
    for (int a = 'h1001; a < 'h100B; a++)
      write_byte(25'(a), 8'(a));
    @(posedge MCLK);
    #1;
    n_cmp++;
    if (n_strobe !== 0 || checksum !== 16'h0 || core_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset strobes=%0d sum=%h crst=%b want 0/0/1",
               n_strobe, checksum, core_reset);
    end
    end_dl();
    @(posedge MCLK);
    #1;
    start_dl();
    write_byte(25'h04000, 8'hAB);
    n_cmp++;
    if (rom_we !== 8'h04 || rom_ad !== 16'h0000 || rom_dt !== 8'hAB) begin
      n_bad++;
      $display("FAIL rearm_write we=%h ad=%h dt=%h want 04/0000/ab",
               rom_we, rom_ad, rom_dt);
    end
    n_cmp++;
    if (checksum !== 16'h00AB) begin
      n_bad++;
      $display("FAIL rearm_sum got %h want 00ab", checksum);
    end
    end_dl();
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_wr_ignored();
    test_boundary();
    test_short_load();
    test_full_load();
    test_user_rst();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
